led_status_ctrl: RTL and testbench

LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

---
 rtl/led_status_ctrl.sv | 106 ++++++++++
 tb/tb_led_status_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: per-channel RGB status LEDs with node-flash and fault overrides.
// Define LED_PWM_DIM_EN to gate all outputs with a 25% duty 4-bit PWM.
module led_status_ctrl #(
  parameter int N_LED        = 3,
  parameter int BLINK_DIV    = 3125,
  parameter int HOLD_TOGGLES = 6,
  parameter int NODE_MIN     = 11
) (
  input  logic             clk_3125KHz,
  input  logic             rst_n,
  input  logic             fault_detect,
  input  logic             node_flag,
  input  logic [7:0]       node,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_idx,
  input  logic [2:0]       cmd_color,
  input  logic [1:0]       cmd_mode,
  output logic [N_LED-1:0] led_r,
  output logic [N_LED-1:0] led_g,
  output logic [N_LED-1:0] led_b,
  output logic             busy
);
  localparam int CW = $clog2(BLINK_DIV);
  typedef enum logic [1:0] {S_NORMAL, S_FLASH, S_FAULT} state_t;
  state_t           r_state, w_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_phase, r_node_q, r_rdy;
  logic [7:0]       r_tog;
  logic [2:0]       r_color [N_LED];
  logic [1:0]       r_mode  [N_LED];
  logic             w_wrap, w_node_ev, w_restart, w_accept, w_last;
  logic [N_LED-1:0] w_r, w_g, w_b, w_gate;
  assign w_wrap    = r_cnt == CW'(BLINK_DIV - 1);
  assign w_node_ev = node_flag && !r_node_q && (int'(node) >= NODE_MIN);
  // Node events only count when nothing of higher priority is active or pending.
  assign w_restart = w_node_ev && !fault_detect && r_state != S_FAULT;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_last    = r_state == S_FLASH && w_wrap && r_tog == 8'(HOLD_TOGGLES - 1);
  assign w_nxt     = fault_detect ? S_FAULT :
                     r_state == S_FAULT ? S_NORMAL :
                     w_restart ? S_FLASH :
                     w_last ? S_NORMAL : r_state;
  assign cmd_ready = r_rdy;
  assign busy      = r_state != S_NORMAL;
`ifdef LED_PWM_DIM_EN
  logic [3:0] r_pwm;
  always_ff @(posedge clk_3125KHz or negedge rst_n)
    if (!rst_n) r_pwm <= '0;
    else r_pwm <= r_pwm + 4'd1;
  assign w_gate = {N_LED{r_pwm < 4'd4}};
`else
  assign w_gate = '1;
`endif
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    for (int i = 0; i < N_LED; i++)
      if (r_mode[i] == 2'b01 || (r_mode[i] == 2'b10 && r_phase) || (r_mode[i] == 2'b11 && !r_phase))
        {w_r[i], w_g[i], w_b[i]} = r_color[i];
    if (r_state == S_FLASH) begin
      w_r = '0;
      w_g = {N_LED{r_phase}};
      w_b = '0;
    end
    if (r_state == S_FAULT) begin
      w_r = '0;
      w_g = '0;
      w_b = '1;
    end
  end
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_NORMAL;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
      r_tog    <= '0;
      r_node_q <= 1'b0;
      r_rdy    <= 1'b0;
      led_r    <= '0;
      led_g    <= '0;
      led_b    <= '0;
      for (int i = 0; i < N_LED; i++) begin
        r_color[i] <= '0;
        r_mode[i]  <= '0;
      end
    end else begin
      r_state  <= w_nxt;
      r_node_q <= node_flag;
      r_rdy    <= w_nxt != S_FAULT;
      r_cnt    <= (w_restart || w_wrap) ? '0 : r_cnt + 1'b1;
      r_phase  <= w_restart ? 1'b1 : w_wrap ? ~r_phase : r_phase;
      r_tog    <= w_restart ? '0 : w_wrap ? r_tog + 8'd1 : r_tog;
      led_r    <= w_r & w_gate;
      led_g    <= w_g & w_gate;
      led_b    <= w_b & w_gate;
      // Out-of-range indices match no channel, so they are silently dropped.
      for (int i = 0; i < N_LED; i++)
        if (w_accept && cmd_idx == 4'(i)) begin
          r_color[i] <= cmd_color;
          r_mode[i]  <= cmd_mode;
        end
    end
  end
endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl: directed stimulus checked every cycle against a timeline model of the LED controller.
module tb_led_status_ctrl;
  localparam int DIV  = 4;
  localparam int HOLD = 6;
  logic       clk = 1'b0, rst_n = 1'b0, fault_detect = 1'b0, node_flag = 1'b0, cmd_valid = 1'b0;
  logic [7:0] node = '0;
  logic [3:0] cmd_idx = '0;
  logic [2:0] cmd_color = '0;
  logic [1:0] cmd_mode = '0;
  logic       cmd_ready, busy;
  logic [2:0] led_r, led_g, led_b;
  int total = 0, bad = 0;
  led_status_ctrl #(.N_LED(3), .BLINK_DIV(DIV), .HOLD_TOGGLES(HOLD), .NODE_MIN(11)) dut (
    .clk_3125KHz(clk), .rst_n(rst_n), .fault_detect(fault_detect), .node_flag(node_flag),
    .node(node), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_idx(cmd_idx),
    .cmd_color(cmd_color), .cmd_mode(cmd_mode), .led_r(led_r), .led_g(led_g),
    .led_b(led_b), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: phase is derived from elapsed cycles since the last counter clear,
  // the flash is a countdown of HOLD*DIV cycles.
  int cyc, base, base_ph, fl_left, p;
  bit m_fault, m_flash, m_rdy, m_prev, ev, acc, on;
  int m_mode [3];
  int m_col [3];
  logic [2:0] e_r, e_g, e_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; base = 0; base_ph = 0; fl_left = 0;
      m_fault = 0; m_flash = 0; m_rdy = 0; m_prev = 0;
      for (int i = 0; i < 3; i++) begin m_mode[i] = 0; m_col[i] = 0; end
    end else begin
      p = base_ph ^ (((cyc - base) / DIV) % 2);
      e_r = '0; e_g = '0; e_b = '0;
      if (m_fault) e_b = 3'b111;
      else if (m_flash) e_g = p == 1 ? 3'b111 : 3'b000;
      else
        for (int i = 0; i < 3; i++) begin
          on = m_mode[i] == 1 || (m_mode[i] == 2 && p == 1) || (m_mode[i] == 3 && p == 0);
          if (on) begin e_r[i] = m_col[i][2]; e_g[i] = m_col[i][1]; e_b[i] = m_col[i][0]; end
        end
      cyc++;
      ev  = node_flag && !m_prev && node >= 8'd11;
      acc = cmd_valid && m_rdy;
      if (fault_detect) begin m_fault = 1; m_flash = 0; end
      else if (m_fault) m_fault = 0;
      else if (ev) begin m_flash = 1; fl_left = HOLD * DIV; base = cyc; base_ph = 1; end
      else if (m_flash) begin fl_left--; if (fl_left == 0) m_flash = 0; end
      if (acc && cmd_idx < 4'd3) begin m_mode[cmd_idx] = int'(cmd_mode); m_col[cmd_idx] = int'(cmd_color); end
      m_prev = node_flag;
      m_rdy  = !m_fault;
      #1;
      if (rst_n) begin
        chk("model_led_r", int'(led_r), int'(e_r));
        chk("model_led_g", int'(led_g), int'(e_g));
        chk("model_led_b", int'(led_b), int'(e_b));
        chk("model_busy", int'(busy), int'(m_fault || m_flash));
        chk("model_cmd_ready", int'(cmd_ready), int'(m_rdy));
      end
    end
  end
  task automatic cmd(int idx, int col, int md);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_idx = 4'(idx); cmd_color = 3'(col); cmd_mode = 2'(md);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic pulse(int n);
    @(negedge clk);
    node = 8'(n); node_flag = 1'b1;
    @(negedge clk);
    node_flag = 1'b0;
  endtask
  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int tr, nb, ng;
    logic pb;
    #12;
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_leds", int'({led_r, led_g, led_b}), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);
    cmd(1, 4, 1);
    wait_n(1);
    chk("solid_red_r", int'(led_r), 2);
    chk("solid_red_gb", int'({led_g, led_b}), 0);
    cmd(0, 1, 2);
    cmd(2, 1, 3);
    wait_n(2);
    tr = 0; pb = led_b[0];
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("antiphase_b0_b2", int'(led_b[0] ^ led_b[2]), 1);
      if (led_b[0] != pb) tr++;
      pb = led_b[0];
    end
    chk("blink_toggles", tr, 4);
    pulse(12);
    nb = 0; ng = 0;
    for (int i = 0; i < 30; i++) begin
      if (i != 0) @(negedge clk);
      if (busy) nb++;
      if (led_g == 3'b111) ng++;
    end
    chk("flash_busy_cycles", nb, 24);
    chk("flash_green_cycles", ng, 12);
    chk("flash_end_busy", int'(busy), 0);
    chk("flash_end_red", int'(led_r), 2);
    pulse(10);
    nb = 0;
    repeat (10) begin @(negedge clk); if (busy) nb++; end
    chk("low_node_ignored", nb, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_idx = 4'd0; cmd_color = 3'b010; cmd_mode = 2'b01; node = 8'd12; node_flag = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; node_flag = 1'b0;
    chk("simul_busy", int'(busy), 1);
    wait_n(5);
    fault_detect = 1'b1;
    wait_n(3);
    chk("fault_blue", int'(led_b), 7);
    chk("fault_green", int'(led_g), 0);
    chk("fault_ready", int'(cmd_ready), 0);
    chk("fault_busy", int'(busy), 1);
    cmd(0, 4, 1);
    pulse(15);
    wait_n(2);
    fault_detect = 1'b0;
    @(negedge clk);
    chk("fault_exit_busy", int'(busy), 0);
    chk("fault_exit_ready", int'(cmd_ready), 1);
    @(negedge clk);
    chk("fault_exit_red", int'(led_r), 2);
    chk("fault_exit_green", int'(led_g), 1);
    wait_n(2);
    chk("flash_not_resumed", int'(busy), 0);
    cmd(5, 7, 1);
    wait_n(1);
    chk("bad_idx_red", int'(led_r), 2);
    chk("bad_idx_green", int'(led_g), 1);
    pulse(12);
    wait_n(3);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midflash_rst_leds", int'({led_r, led_g, led_b}), 0);
    chk("midflash_rst_busy", int'(busy), 0);
    chk("midflash_rst_ready", int'(cmd_ready), 0);
    wait_n(2);
    rst_n = 1'b1;
    wait_n(3);
    chk("post_rst_leds", int'({led_r, led_g, led_b}), 0);
    chk("post_rst_busy", int'(busy), 0);
    wait_n(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
